// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and state encoding for the pipeline stage register
package pipe_pkg;

    // Occupancy encoding as reported on the occupancy port.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Skid-mode FSM states; encoded to match the occupancy values.
    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+data holding register with load and clear
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   load          capture d and mark the slot valid
//   clear         drop valid (data is kept); wins over load
//   d             payload to capture
//   valid, q      held valid flag and payload
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid/ready, optional skid and flush
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   flush                 kill held entries and the entry offered this cycle
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload
//   occupancy             number of held entries (0..2)
// The low CTRL_W payload bits are forced to zero whenever out_valid is low,
// so a bubble never triggers a write enable or strobe downstream.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              accept;
    logic              out_xfer;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d;
    logic              main_valid;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] ctrl_mask;

    // An offered entry during flush is consumed and dropped, never loaded.
    assign accept    = in_valid & in_ready & ~flush;
    assign out_xfer  = out_valid & out_ready;
    assign out_valid = main_valid;

    pipe_slot #(.DATA_W(DATA_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    generate
        if (SKID == 0) begin : g_single
            // Ready whenever the current entry is gone or leaving this edge.
            assign in_ready   = ~main_valid | out_ready;
            assign main_load  = accept;
            assign main_d     = in_data;
            assign main_clear = flush | (out_xfer & ~accept);
            assign occupancy  = main_valid ? OCC_ONE : OCC_EMPTY;
        end else begin : g_skid
            skid_state_e       state;
            skid_state_e       state_nxt;
            logic              in_ready_q;
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_q;
            logic              m_load;
            logic              m_clear;
            logic [DATA_W-1:0] m_d;

            pipe_slot #(.DATA_W(DATA_W)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clear (skid_clear),
                .d     (in_data),
                .valid (skid_valid),
                .q     (skid_q)
            );

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state      <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state      <= state_nxt;
                    // Registered ready: drops the edge the stage becomes full.
                    in_ready_q <= (state_nxt != ST_FULL);
                end
            end

            always_comb begin
                state_nxt  = state;
                m_load     = 1'b0;
                m_clear    = 1'b0;
                m_d        = in_data;
                skid_load  = 1'b0;
                skid_clear = 1'b0;
                case (state)
                    ST_EMPTY: begin
                        if (accept) begin
                            state_nxt = ST_ONE;
                            m_load    = 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (accept && out_xfer) begin
                            m_load = 1'b1;
                        end else if (accept) begin
                            state_nxt = ST_FULL;
                            skid_load = 1'b1;
                        end else if (out_xfer) begin
                            state_nxt = ST_EMPTY;
                            m_clear   = 1'b1;
                        end
                    end
                    ST_FULL: begin
                        if (out_xfer) begin
                            state_nxt  = ST_ONE;
                            m_load     = 1'b1;
                            m_d        = skid_q;
                            skid_clear = 1'b1;
                        end
                    end
                    default: state_nxt = ST_EMPTY;
                endcase
                if (flush) begin
                    state_nxt  = ST_EMPTY;
                    m_load     = 1'b0;
                    skid_load  = 1'b0;
                    m_clear    = 1'b1;
                    skid_clear = 1'b1;
                end
            end

            assign in_ready   = in_ready_q;
            assign main_load  = m_load;
            assign main_clear = m_clear;
            assign main_d     = m_d;
            assign occupancy  = skid_valid ? OCC_FULL : (main_valid ? OCC_ONE : OCC_EMPTY);
        end
    endgenerate

    always_comb begin
        ctrl_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ctrl_mask[i] = (i < CTRL_W);
        end
    end

    // Upper bits show stale main contents; only the control bits are gated.
    assign out_data = out_valid ? main_q : (main_q & ~ctrl_mask);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg in skid and single modes
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst;

    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;

    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0]  b_in_data, b_out_data;
    logic [1:0]   b_occ;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] qa[$];
    logic [15:0]  qb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(4), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .SKID(0)) u_single (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    // Scoreboard for the skid instance: sampled late in the low phase.
    always begin
        logic [127:0] exp_a;
        @(negedge clk);
        #4;
        if (!rst) begin
            qa.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                n_tests++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a_unexpected got=%h required=none", a_out_data);
                end else begin
                    exp_a = qa.pop_front();
                    if (a_out_data !== exp_a) begin
                        n_fail++;
                        $display("FAIL sb_a_data got=%h required=%h", a_out_data, exp_a);
                    end
                end
            end
            if (!a_out_valid) begin
                n_tests++;
                if (a_out_data[3:0] !== 4'h0) begin
                    n_fail++;
                    $display("FAIL a_bubble_ctrl got=%h required=0", a_out_data[3:0]);
                end
            end
            if (a_flush) qa.delete();
            else if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
        end
    end

    // Scoreboard for the single-register instance.
    always begin
        logic [15:0] exp_b;
        @(negedge clk);
        #4;
        if (!rst) begin
            qb.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                n_tests++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b_unexpected got=%h required=none", b_out_data);
                end else begin
                    exp_b = qb.pop_front();
                    if (b_out_data !== exp_b) begin
                        n_fail++;
                        $display("FAIL sb_b_data got=%h required=%h", b_out_data, exp_b);
                    end
                end
            end
            if (b_flush) qb.delete();
            else if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
        end
    end

    task automatic test_reset;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1 || a_out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_init_a got v=%b occ=%0d rdy=%b required v=0 occ=0 rdy=1", a_out_valid, a_occ, a_in_ready);
        end
        n_tests++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_init_b got v=%b rdy=%b occ=%0d required v=0 rdy=1 occ=0", b_out_valid, b_in_ready, b_occ);
        end
        @(negedge clk);
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 128'd1; a_out_ready = 1'b0;
        @(negedge clk);
        a_in_data = 128'd2;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        n_tests++;
        if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fill got occ=%0d rdy=%b required occ=2 rdy=0", a_occ, a_in_ready);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== '0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async got v=%b occ=%0d data=%h rdy=%b required v=0 occ=0 data=0 rdy=1",
                     a_out_valid, a_occ, a_out_data, a_in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stream;
        for (int k = 1; k <= 16; k++) begin
            a_in_valid = 1'b1; a_in_data = 128'(k); a_out_ready = 1'b1;
            #1;
            if (k > 1) begin
                n_tests++;
                if (a_out_valid !== 1'b1 || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_k%0d got v=%b occ=%0d rdy=%b required v=1 occ=1 rdy=1", k, a_out_valid, a_occ, a_in_ready);
                end
            end
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_data !== 128'd16) begin
            n_fail++;
            $display("FAIL stream_last got v=%b data=%h required v=1 data=10", a_out_valid, a_out_data);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || qa.size() != 0) begin
            n_fail++;
            $display("FAIL stream_drain got v=%b left=%0d required v=0 left=0", a_out_valid, qa.size());
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] list [3];
        int idx;
        logic acc;
        list[0] = 128'hA; list[1] = 128'hB; list[2] = 128'hC;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            a_in_valid  = (idx < 3);
            a_in_data   = (idx < 3) ? list[idx] : '0;
            a_out_ready = (c >= 3);
            #1;
            if (c == 2 || c == 3) begin
                n_tests++;
                if (a_in_ready !== 1'b0 || a_occ !== 2'd2 || a_out_data !== 128'hA) begin
                    n_fail++;
                    $display("FAIL bp_full_c%0d got rdy=%b occ=%0d data=%h required rdy=0 occ=2 data=a",
                             c, a_in_ready, a_occ, a_out_data);
                end
            end
            acc = a_in_valid && a_in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        #1;
        n_tests++;
        if (idx != 3 || qa.size() != 0 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain got sent=%0d left=%0d v=%b required sent=3 left=0 v=0", idx, qa.size(), a_out_valid);
        end
    endtask

    task automatic test_flush;
        a_in_valid = 1'b1; a_in_data = 128'h21; a_out_ready = 1'b0;
        @(negedge clk);
        a_in_data = 128'h22;
        @(negedge clk);
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 128'hF; a_out_ready = 1'b1;
        #1;
        n_tests++;
        if (a_occ !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_pre got occ=%0d required occ=2", a_occ);
        end
        @(negedge clk);
        a_flush = 1'b0; a_in_valid = 1'b0;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_full got v=%b occ=%0d required v=0 occ=0", a_out_valid, a_occ);
        end
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 128'h31; a_out_ready = 1'b0;
        @(negedge clk);
        a_flush = 1'b1; a_in_data = 128'hF;
        @(negedge clk);
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_one got v=%b occ=%0d required v=0 occ=0", a_out_valid, a_occ);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bubble;
        a_in_valid = 1'b1; a_in_data = 128'hFFF; a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_data !== 128'hFFF) begin
            n_fail++;
            $display("FAIL bubble_live got v=%b data=%h required v=1 data=fff", a_out_valid, a_out_data);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_out_data[3:0] !== 4'h0 || a_out_data[127:4] !== 124'hFF) begin
            n_fail++;
            $display("FAIL bubble_gate got v=%b data=%h required v=0 data=ff0", a_out_valid, a_out_data);
        end
    endtask

    task automatic test_single;
        b_in_valid = 1'b1; b_in_data = 16'h11; b_out_ready = 1'b0;
        #1;
        n_tests++;
        if (b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_empty_rdy got=%b required=1", b_in_ready);
        end
        @(negedge clk);
        b_in_data = 16'h22;
        #1;
        n_tests++;
        if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 || b_occ !== 2'd1) begin
            n_fail++;
            $display("FAIL single_stall got v=%b rdy=%b occ=%0d required v=1 rdy=0 occ=1", b_out_valid, b_in_ready, b_occ);
        end
        #1 b_out_ready = 1'b1;
        #1;
        n_tests++;
        if (b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_comb_rdy got=%b required=1", b_in_ready);
        end
        @(negedge clk);
        for (int k = 3; k <= 6; k++) begin
            b_in_data = 16'(k * 16'h11);
            #1;
            n_tests++;
            if (b_in_ready !== 1'b1 || b_out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL single_b2b_k%0d got rdy=%b v=%b required rdy=1 v=1", k, b_in_ready, b_out_valid);
            end
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (b_out_valid !== 1'b0 || qb.size() != 0 || b_out_data[3:0] !== 4'h0) begin
            n_fail++;
            $display("FAIL single_drain got v=%b left=%0d ctrl=%h required v=0 left=0 ctrl=0", b_out_valid, qb.size(), b_out_data[3:0]);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
        test_single();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register: the successor to the fixed decode-to-execute latch, for every stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB) of the dynamic-pipeline CPU. It carries an opaque payload bus with a valid/ready handshake, an optional skid entry for registered backpressure, and a flush input for branch/jump kill. When no valid entry is presented, the low CTRL_W payload bits (write enables, LW/JAL/MUL strobes) are forced to zero, so a bubble is architecturally a no-op.

## Interface
- DATA_W, 128: payload width in bits; bits [CTRL_W-1:0] are side-effect control bits.
- CTRL_W, 4: number of low payload bits zeroed on bubble/flush; 0 ≤ CTRL_W ≤ DATA_W.
- SKID, 1: 0 = single register, combinational in_ready; 1 = main + skid register, in_ready is a flop output.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kill all held entries and the entry offered this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload; bits [CTRL_W-1:0] are 0 whenever out_valid=0.
- occupancy  out  2  held entries (0..1 for SKID=0, 0..2 for SKID=1).

## Operation
- Transfer in: in_valid & in_ready & !flush. Transfer out: out_valid & out_ready.
- Reset (rst=0): out_valid=0, occupancy=0, main and skid data=0; in_ready=1 (SKID=1 flop resets to 1; SKID=0 is derived).
- SKID=0: in_ready = !out_valid | out_ready. Accepted entry loads main the same edge the old one leaves; otherwise main holds.
- SKID=1: states EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & out -> ONE (main reloads); accept & !out -> FULL (input goes to skid); out & !accept -> EMPTY; else hold.
  - FULL: in_ready=0; out -> ONE, skid moves to main; else hold.
  - in_ready registered: 1 in EMPTY/ONE, 0 in FULL.
- flush: next state EMPTY/occupancy 0 regardless of other inputs; offered entry discarded (in_ready may read 1; transfer counts as consumed and dropped); an out transfer in the flush cycle still completes.
- Data not cleared on flush/out; only valid drops. out_data[CTRL_W-1:0] gated by out_valid combinationally; upper bits show stale main contents.
- No payload arithmetic; width generic; CTRL_W=0 disables gating.

## Timing
- Latency in->out: 1 cycle (entry accepted at edge N is out_valid after edge N).
- Throughput: 1 entry/cycle with out_ready held 1, both modes.
- SKID=1 backpressure: out_ready low one cycle -> at most one extra entry absorbed, in_ready low from the next edge.
- flush effective at the next edge; out_valid=0 the cycle after.
- Reset asynchronous assert, outputs cleared immediately; deassert synchronous to clk by upstream synchroniser.

## Structure
- Package pipe_pkg: occupancy encoding constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2; state typedef for SKID=1 FSM.
- One sub-module natural: pipe_slot (DATA_W-wide valid+data register with load/clear), instanced once or twice.
- Stage-specific field packing lives in the CPU top, not here.

## Test plan
- Reset: rst=0 mid-stream with occupancy=2 -> immediately out_valid=0, occupancy=0, out_data=0; SKID=1 in_ready=1.
- Streaming, SKID=1, DATA_W=128: in_valid=1 with payload counter 1..16, out_ready=1 -> outputs 1..16 one cycle late, no gaps, occupancy=1.
- Backpressure: out_ready=0 for 3 cycles while streaming 0xA,0xB,0xC -> SKID=1 holds A (main), B (skid), in_ready=0, C held upstream; release -> A,B,C in order, none lost or duplicated.
- Flush: occupancy=2, flush=1 with in_valid=1 data 0xF -> next cycle out_valid=0, occupancy=0, 0xF never appears.
- Bubble gating: CTRL_W=4, in_data=0xFF_F accepted then out_valid falls -> out_data[3:0]=0 while out_valid=0, upper bits unchanged.
- SKID=0: out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 combinationally, back-to-back transfer.
